// File: rtl/data_cache_sa.sv
// N-way set-associative write-back/write-allocate data cache with RISC-V sub-word access and per-set round-robin.
// Optional DCACHE_PERF_COUNTERS_EN adds hit/miss/writeback counter outputs.
module data_cache_sa #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       read,
    input  logic                       write,
    input  logic                       inst_hit,
    input  logic [2:0]                 funct3,
    input  logic [ADDR_W-1:0]          address,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [32*LINE_WORDS-1:0]   mem_writedata,
    input  logic [32*LINE_WORDS-1:0]   mem_readdata,
    input  logic                       mem_busywait
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]                perf_hits,
    output logic [31:0]                perf_misses,
    output logic [31:0]                perf_writebacks
`endif
);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             all_valid_q, all_valid_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] wsel;
    logic [1:0]        bsel;

    assign idx     = address[OFF_W +: IDX_W];
    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign wsel    = WSEL_W'((address >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign bsel    = address[1:0];

    logic             req, hit, store_hit, fill_done, inv_found;
    logic [WAYS-1:0]  match;
    logic [WAY_W-1:0] hit_way, inv_way, rr_next;

    assign req = inst_hit & (read ^ write);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign match[gi] = valid_q[idx][gi] && (tag_q[idx][gi] == req_tag);
        end
    endgenerate

    // Descending scan leaves the lowest-index match / invalid way selected.
    always_comb begin
        hit_way   = '0;
        inv_way   = '0;
        inv_found = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign hit       = req & (|match);
    assign store_hit = (state_q == IDLE) && hit && write;
    assign rr_next   = WAY_W'((int'(rr_q[idx]) + 1) % WAYS);
    assign busywait  = (state_q != IDLE) | (req & ~hit);

    logic [LINE_W-1:0] hit_line, merged_line;
    logic [31:0]       hit_word, merged_word, st_data, load_ext;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [3:0]        be;

    assign hit_line = data_q[idx][hit_way];
    assign hit_word = hit_line[32*wsel +: 32];

    always_comb begin
        ld_byte = hit_word[8*bsel +: 8];
        ld_half = address[1] ? hit_word[31:16] : hit_word[15:0];
        case (funct3)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = hit_word;
        endcase
        readdata = hit ? load_ext : 32'b0;
    end

    // Sub-word stores replicate the data across lanes and pick lanes with a byte enable.
    always_comb begin
        case (funct3)
            3'b000: begin
                be      = 4'b0001 << bsel;
                st_data = {4{writedata[7:0]}};
            end
            3'b001: begin
                be      = address[1] ? 4'b1100 : 4'b0011;
                st_data = {2{writedata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                st_data = writedata;
            end
        endcase
        for (int l = 0; l < 4; l++)
            merged_word[8*l +: 8] = be[l] ? st_data[8*l +: 8] : hit_word[8*l +: 8];
        merged_line = hit_line;
        merged_line[32*wsel +: 32] = merged_word;
    end

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        all_valid_d = all_valid_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        fill_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    all_valid_d = !inv_found;
                    victim_d    = inv_found ? inv_way : rr_q[idx];
                    state_d     = dirty_q[idx][victim_d] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
                if (!mem_busywait) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, idx, {OFF_W{1'b0}}};
                if (!mem_busywait) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_writedata = data_q[idx][victim_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            victim_q    <= '0;
            all_valid_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            all_valid_q <= all_valid_d;
            if (store_hit) dirty_q[idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
                if (all_valid_q) rr_q[idx] <= rr_next;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (store_hit) data_q[idx][hit_way] <= merged_line;
            if (fill_done) begin
                data_q[idx][victim_q] <= mem_readdata;
                tag_q[idx][victim_q]  <= req_tag;
            end
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hits_q, misses_q, wbs_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if ((state_q == IDLE) && hit) hits_q <= hits_q + 32'd1;
            if ((state_q == IDLE) && (state_d != IDLE)) misses_q <= misses_q + 32'd1;
            if ((state_q == WRITEBACK) && !mem_busywait) wbs_q <= wbs_q + 32'd1;
        end
    end

    assign perf_hits       = hits_q;
    assign perf_misses     = misses_q;
    assign perf_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_data_cache_sa.sv
// Self-checking bench for data_cache_sa: latency-5 line memory model, architectural reference memory
// and a queue of expected load results.
module tb_data_cache_sa;
    localparam int LW      = 4;
    localparam int MEM_LAT = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              read = 1'b0, write = 1'b0, inst_hit = 1'b0;
    logic [2:0]        funct3 = 3'b010;
    logic [31:0]       address = '0, writedata = '0;
    logic [31:0]       readdata;
    logic              busywait, mem_read, mem_write;
    logic [31:0]       mem_address;
    logic [LW*32-1:0]  mem_writedata;
    logic [LW*32-1:0]  mem_readdata = '0;
    logic              mem_busywait = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] exp_q [$];

    logic        wb_seen, al_seen, both_seen;
    logic [31:0] wb_addr, wb_word0, al_addr, last_rd;
    int          mcnt = 0;

    always #5 clock = ~clock;

    data_cache_sa dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .inst_hit      (inst_hit),
        .funct3        (funct3),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hA500_0000 | (a & 32'h00FF_FFFC);
    endfunction

    function automatic logic [31:0] bget(input logic [31:0] a);
        logic [31:0] k = {a[31:2], 2'b00};
        return bmem.exists(k) ? bmem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        logic [31:0] k = {a[31:2], 2'b00};
        return refm.exists(k) ? refm[k] : init_word(k);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w = rget(a);
        logic [7:0]  b = w[8*a[1:0] +: 8];
        logic [15:0] h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w = rget(a);
        case (f3)
            3'b000:  w[8*a[1:0] +: 8] = d[7:0];
            3'b001:  if (a[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
            default: w = d;
        endcase
        refm[{a[31:2], 2'b00}] = w;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Line memory: MEM_LAT cycles per transaction, last one with mem_busywait low.
    always @(negedge clock) begin
        if (reset || !(mem_read || mem_write)) begin
            mcnt = 0;
            mem_busywait = 1'b0;
        end else if (mcnt == MEM_LAT - 1) begin
            mcnt = 0;
            mem_busywait = 1'b0;
            if (mem_write)
                for (int w = 0; w < LW; w++) bmem[mem_address + 32'(4*w)] = mem_writedata[32*w +: 32];
            if (mem_read)
                for (int w = 0; w < LW; w++) mem_readdata[32*w +: 32] = bget(mem_address + 32'(4*w));
        end else begin
            mcnt++;
            mem_busywait = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access has been accepted.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int exp_busy, input string tag);
        int busy = 0;
        bit done = 0;
        read = rd; write = wr; inst_hit = 1'b1; funct3 = f3; address = a; writedata = d;
        if (rd) exp_q.push_back(ref_load(f3, a));
        else ref_store(f3, a, d);
        wb_seen = 0; al_seen = 0; both_seen = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clock); #1;
            if (mem_read && mem_write) both_seen = 1;
            if (mem_write && !wb_seen) begin
                wb_seen = 1; wb_addr = mem_address; wb_word0 = mem_writedata[31:0];
            end
            if (mem_read && !al_seen) begin
                al_seen = 1; al_addr = mem_address;
            end
            if (!busywait) begin
                done = 1;
                last_rd = readdata;
                if (rd) check_val({tag, "_rdata"}, readdata, exp_q.pop_front());
            end else begin
                busy++;
            end
        end
        if (!done && rd) void'(exp_q.pop_front());
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        check_val({tag, "_rd_wr_overlap"}, 32'(both_seen), 32'd0);
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    // Non-requests held for a few cycles must not stall or touch memory.
    task automatic quiet_req(input logic rd, input logic wr, input logic ih, input logic [31:0] a,
                             input logic [31:0] d, input string tag);
        logic seen = 1'b0;
        read = rd; write = wr; inst_hit = ih; funct3 = 3'b010; address = a; writedata = d;
        repeat (3) begin
            @(negedge clock); #1;
            seen = seen | busywait | mem_read | mem_write;
        end
        check_val({tag, "_activity"}, 32'(seen), 32'd0);
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0; inst_hit = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; read = 1'b0; write = 1'b0; inst_hit = 1'b0;
        repeat (cycles) @(posedge clock);
        #1 reset = 1'b0;
        refm = bmem;
        @(negedge clock); #1;
        check_val("rst_busywait", 32'(busywait), 32'd0);
        check_val("rst_mem_read", 32'(mem_read), 32'd0);
        check_val("rst_mem_write", 32'(mem_write), 32'd0);
        check_val("rst_readdata", readdata, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        logic got_alloc;

        do_reset(3);

        // Clean miss then sub-word traffic on the same line.
        access(1, 0, 3'b010, 32'h40, 0, MEM_LAT + 1, "lw40");
        check_val("lw40_alloc_addr", al_addr, 32'h40);
        check_val("lw40_wb", 32'(wb_seen), 32'd0);
        access(0, 1, 3'b000, 32'h41, 32'h80, 0, "sb41");
        check_val("sb41_mem_traffic", 32'(wb_seen | al_seen), 32'd0);
        access(1, 0, 3'b000, 32'h41, 0, 0, "lb41");
        check_val("lb41_value", last_rd, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h41, 0, 0, "lbu41");
        check_val("lbu41_value", last_rd, 32'h0000_0080);
        check_val("lbu41_mem_traffic", 32'(wb_seen | al_seen), 32'd0);
        access(0, 1, 3'b001, 32'h46, 32'h1234_8001, 0, "sh46");
        access(1, 0, 3'b001, 32'h46, 0, 0, "lh46");
        access(1, 0, 3'b101, 32'h47, 0, 0, "lhu47");
        access(1, 0, 3'b001, 32'h45, 0, 0, "lh45");
        access(0, 1, 3'b011, 32'h48, 32'h1234_5678, 0, "s011_48");
        access(1, 0, 3'b010, 32'h4B, 0, 0, "lw4b");
        check_val("lw4b_value", last_rd, 32'h1234_5678);
        access(1, 0, 3'b000, 32'h4B, 0, 0, "lb4b");
        access(1, 0, 3'b110, 32'h44, 0, 0, "l110_44");
        access(1, 0, 3'b010, 32'h4C, 0, 0, "lw4c");

        // Round-robin replacement in set 0.
        do_reset(2);
        access(1, 0, 3'b010, 32'h000, 0, MEM_LAT + 1, "rr_000");
        access(1, 0, 3'b010, 32'h080, 0, MEM_LAT + 1, "rr_080");
        access(1, 0, 3'b010, 32'h100, 0, MEM_LAT + 1, "rr_100");
        check_val("rr_100_wb", 32'(wb_seen), 32'd0);
        access(1, 0, 3'b010, 32'h080, 0, 0, "rr_080_hit");
        access(1, 0, 3'b010, 32'h000, 0, MEM_LAT + 1, "rr_000_again");
        access(1, 0, 3'b010, 32'h100, 0, 0, "rr_100_hit");
        access(1, 0, 3'b010, 32'h080, 0, MEM_LAT + 1, "rr_080_refill");

        // Dirty eviction goes through writeback before the fill.
        do_reset(2);
        access(0, 1, 3'b010, 32'h000, 32'hDEAD_BEEF, MEM_LAT + 1, "sw_000");
        access(1, 0, 3'b010, 32'h080, 0, MEM_LAT + 1, "d_080");
        access(1, 0, 3'b010, 32'h100, 0, 2*MEM_LAT + 1, "d_100");
        check_val("d_100_wb_seen", 32'(wb_seen), 32'd1);
        check_val("d_100_wb_addr", wb_addr, 32'h000);
        check_val("d_100_wb_word0", wb_word0, 32'hDEAD_BEEF);
        check_val("d_100_alloc_addr", al_addr, 32'h100);
        access(1, 0, 3'b010, 32'h180, 0, MEM_LAT + 1, "d_180");
        check_val("d_180_wb", 32'(wb_seen), 32'd0);
        access(1, 0, 3'b010, 32'h000, 0, MEM_LAT + 1, "d_000_reload");

        // Reset while a fill is in progress.
        read = 1'b1; write = 1'b0; inst_hit = 1'b1; funct3 = 3'b010; address = 32'h200;
        got_alloc = 1'b0;
        for (int c = 0; c < 20 && !got_alloc; c++) begin
            @(negedge clock); #1;
            if (mem_read) got_alloc = 1'b1;
        end
        check_val("mid_alloc_seen", 32'(got_alloc), 32'd1);
        @(posedge clock); #1;
        do_reset(1);
        access(1, 0, 3'b010, 32'h200, 0, MEM_LAT + 1, "mid_retry_200");

        // Qualified-off and read+write requests are ignored.
        quiet_req(1, 0, 0, 32'h300, 0, "ih0_read");
        quiet_req(1, 1, 1, 32'h300, 0, "rdwr_both");
        quiet_req(0, 1, 0, 32'h200, 32'hCAFE_F00D, "ih0_write");
        access(1, 0, 3'b010, 32'h300, 0, MEM_LAT + 1, "post_quiet_300");
        access(1, 0, 3'b010, 32'h200, 0, 0, "post_quiet_200");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_cache_sa.md
Name: data_cache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the pipeline MEM stage and the line-wide data memory.
- Successor to the single-way, 8-line data cache: configurable sets, ways and line size, with the miss FSM integrated.
- Adds RISC-V byte, half and word loads and stores (sign and zero extension) and per-set round-robin replacement.

Parameters:
- ADDR_W, 32, byte-address width.
- SETS, 8, number of sets (power of 2, ≥2).
- WAYS, 2, associativity (power of 2, ≥1).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥1).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- read  in  1  load request.
- write  in  1  store request.
- inst_hit  in  1  request qualifier; the request is ignored when 0.
- funct3  in  3  RISC-V load/store funct3.
- address  in  ADDR_W  byte address.
- writedata  in  32  store data, right-aligned.
- readdata  out  32  load result, extended.
- busywait  out  1  stall to the pipeline.
- mem_read  out  1  line fetch request.
- mem_write  out  1  line writeback request.
- mem_address  out  ADDR_W  line-aligned address.
- mem_writedata  out  32*LINE_WORDS  victim line.
- mem_readdata  in  32*LINE_WORDS  fill line.
- mem_busywait  in  1  memory busy.

Behaviour:
- Address split:
  - offset = log2(LINE_WORDS*4) bits.
  - index = log2(SETS) bits.
  - tag = remaining bits.
- Request: req = inst_hit & (read ^ write). read & write together counts as no request.
- Hit: req, and some way in the indexed set is valid with a matching tag. At most one way can match.
- States IDLE, WRITEBACK, ALLOCATE.
  - IDLE, hit: zero-wait access.
    - readdata is valid combinationally in the same cycle.
    - busywait=0.
    - A store merges at posedge and sets the way's dirty bit.
  - IDLE, miss: victim = lowest-index invalid way; if all ways are valid, victim = rr[index].
    - Victim dirty → WRITEBACK.
    - Victim clean → ALLOCATE.
  - WRITEBACK: mem_write=1, mem_address={victim tag, index, 0}, mem_writedata=victim line.
    - At a posedge with mem_busywait=0 → ALLOCATE.
  - ALLOCATE: mem_read=1, mem_address={tag, index, 0}.
    - At a posedge with mem_busywait=0: write mem_readdata into the victim way, set valid=1, dirty=0, tag=request tag.
    - If all ways were valid, rr[index] += 1 (wraps at WAYS) → IDLE.
    - The access then hits in the following cycle.
- busywait = (state≠IDLE) | (req & ~hit). It stays high in the cycle that returns to IDLE and drops in the hit cycle.
- Miss latency: clean miss = fill cycles + 1; dirty miss adds the writeback cycles.
- mem_read and mem_write are never high together; both are 0 in IDLE.
- The requester holds address, funct3, writedata, read and write stable while busywait=1. A changed request during a miss has undefined result; the FSM still completes.
- Loads:
  - funct3 000 LB, 100 LBU: byte at address[1:0].
  - funct3 001 LH, 101 LHU: half at address[1].
  - funct3 010 LW: word.
  - Signed loads sign-extend; unsigned loads zero-extend.
  - Other funct3 codes return the word.
- Stores:
  - funct3 000 SB updates 1 byte lane; 001 SH updates 2 lanes; 010 SW updates 4 lanes.
  - Other funct3 codes are treated as SW.
- Misaligned half or word accesses align down. No exception is raised.
- readdata when not hitting: don't-care, but never X after reset.
- Reset (synchronous, any state, including mid-transaction):
  - State → IDLE.
  - All valid, dirty and rr bits = 0.
  - mem_read=0, mem_write=0, busywait=0, readdata=0.
  - The in-flight memory transaction is abandoned; data arrays need not be cleared.

Optional Feature:
- Macro DCACHE_PERF_COUNTERS_EN.
- Defined: adds 32-bit outputs perf_hits, perf_misses, perf_writebacks.
  - perf_hits increments once per accepted IDLE hit cycle (~busywait & req).
  - perf_misses increments on IDLE→WRITEBACK or IDLE→ALLOCATE.
  - perf_writebacks increments on WRITEBACK→ALLOCATE.
  - Counters wrap, and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then LW 0x0000_0040 with a 5-cycle memory → busywait high, ALLOCATE, mem_address=0x40. Following cycle: hit, readdata = word 0 of the fill line, busywait=0.
- SB 0x80 to 0x0000_0041, then LB 0x41 → readdata=0xFFFF_FF80. LBU 0x41 → 0x0000_0080. Neither raises mem traffic.
- SETS=8, WAYS=2, LINE_WORDS=4: fill 0x000 and 0x080 (same set, both ways), then read 0x100 → evicts way 0 (rr=0). rr[0] becomes 1. Reading 0x080 still hits.
- Dirty eviction: SW 0xDEADBEEF to 0x000, fill 0x080, then access 0x100 and 0x180. WRITEBACK must present mem_address=0x000 with the line containing 0xDEADBEEF before ALLOCATE 0x100.
- Assert reset in ALLOCATE mid-fill → next cycle mem_read=0, busywait=0. The prior address then misses.
- inst_hit=0 with read=1, and separately read=write=1 → busywait=0, no state change, no mem request.
